// File: rtl/instruction_memory_bank.sv
// instruction_memory_bank: DEPTH x 32-bit instruction store with a registered
// fetch port, a loader write port and a self-clearing sweep after reset.
// Optional build macro IMEM_FAULT_CHECK_EN turns on fetch-address fault
// checking; without it the row index simply wraps modulo DEPTH.
module instruction_memory_bank #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             FetchReq,
  input  logic [31:0]      Address,
  output logic [31:0]      ReadData,
  output logic             FetchValid,
  output logic             Busy,
  input  logic             ProgWE,
  input  logic [IDX_W-1:0] ProgAddr,
  input  logic [31:0]      ProgData,
  output logic             Fault
);

  localparam int unsigned DATA_W = 32;
  localparam logic [DATA_W-1:0] NOP_WORD = DATA_W'(32'h0000_0013);
  localparam logic [IDX_W-1:0]  LAST_ROW = IDX_W'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               valid_q, valid_d;
  logic               fault_q, fault_d;
  logic               busy_q, busy_d;

  logic [DATA_W-1:0]  mem_q [DEPTH];

  logic               wr_en_c;
  logic [IDX_W-1:0]   wr_idx_c;
  logic [DATA_W-1:0]  wr_data_c;
  logic [IDX_W-1:0]   fetch_idx_c;
  logic               addr_fault_c;

  // Word index taken from the byte address.
  assign fetch_idx_c = Address[IDX_W+1:2];

`ifdef IMEM_FAULT_CHECK_EN
  // Misaligned or beyond-the-array addresses are faults.
  assign addr_fault_c = (|Address[1:0]) | (|Address[31:IDX_W+2]);
`else
  // Upper and byte-offset bits are don't-care; index wraps modulo DEPTH.
  logic addr_unused_c;
  assign addr_unused_c = ^{Address[31:IDX_W+2], Address[1:0]};
  assign addr_fault_c  = 1'b0;
`endif

  // Next-state, memory-write and fetch-result logic.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    rdata_d   = rdata_q;
    valid_d   = 1'b0;
    fault_d   = 1'b0;
    wr_en_c   = 1'b0;
    wr_idx_c  = ptr_q;
    wr_data_c = '0;

    case (state_q)
      ST_CLEAR: begin
        // Sweep zeroes one row per cycle; loader and fetch are dropped.
        wr_en_c   = 1'b1;
        wr_idx_c  = ptr_q;
        wr_data_c = '0;
        if (ptr_q == LAST_ROW) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + IDX_W'(1);
        end
      end
      ST_IDLE: begin
        if (ProgWE) begin
          wr_en_c   = 1'b1;
          wr_idx_c  = ProgAddr;
          wr_data_c = ProgData;
        end
        // Read uses pre-edge array contents, so a same-row write returns old data.
        if (FetchReq) begin
          valid_d = 1'b1;
          if (addr_fault_c) begin
            fault_d = 1'b1;
            rdata_d = NOP_WORD;
          end else begin
            rdata_d = mem_q[fetch_idx_c];
          end
        end
      end
      default: begin
        state_d = ST_CLEAR;
        ptr_d   = '0;
      end
    endcase

    busy_d = (state_d == ST_CLEAR);
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
      busy_q  <= busy_d;
    end
  end

  // Instruction array; contents are initialised by the sweep, not by reset.
  always_ff @(posedge CLK) begin
    if (wr_en_c && !RESET) begin
      mem_q[wr_idx_c] <= wr_data_c;
    end
  end

  assign ReadData   = rdata_q;
  assign FetchValid = valid_q;
  assign Fault      = fault_q;
  assign Busy       = busy_q;

endmodule

// File: tb/tb_instruction_memory_bank.sv
// Directed bench for instruction_memory_bank (DEPTH = 64).
module tb_instruction_memory_bank;

  logic        clk;
  logic        reset;
  logic        fetch_req;
  logic [31:0] address;
  logic [31:0] read_data;
  logic        fetch_valid;
  logic        busy;
  logic        prog_we;
  logic [5:0]  prog_addr;
  logic [31:0] prog_data;
  logic        fault;

  int checks = 0;
  int errors = 0;
  int n;

  instruction_memory_bank #(.DEPTH(64)) dut (
    .CLK(clk),
    .RESET(reset),
    .FetchReq(fetch_req),
    .Address(address),
    .ReadData(read_data),
    .FetchValid(fetch_valid),
    .Busy(busy),
    .ProgWE(prog_we),
    .ProgAddr(prog_addr),
    .ProgData(prog_data),
    .Fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fetch_check(input string tag, input logic [31:0] addr,
                             input logic [31:0] exp_data, input logic exp_fault);
    fetch_req = 1'b1;
    address   = addr;
    tick();
    fetch_req = 1'b0;
    check({tag, "_valid"}, 32'(fetch_valid), 32'd1);
    check({tag, "_data"}, read_data, exp_data);
    check({tag, "_fault"}, 32'(fault), 32'(exp_fault));
  endtask

  task automatic prog(input logic [5:0] row, input logic [31:0] data);
    prog_we   = 1'b1;
    prog_addr = row;
    prog_data = data;
    tick();
    prog_we   = 1'b0;
  endtask

  initial begin
    reset = 1'b1; fetch_req = 1'b0; address = '0;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0;

    // Reset state
    tick();
    check("rst_rdata", read_data, 32'h0);
    check("rst_valid", 32'(fetch_valid), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    reset = 1'b0;

    // Clear sweep length
    n = 0;
    while (busy && n < 200) begin
      n++;
      tick();
    end
    check("clear_cycles", 32'(n), 32'd64);

    // Fetch of a cleared row, then hold
    fetch_check("fetch_0x10", 32'h10, 32'h0, 1'b0);
    tick();
    check("idle_valid", 32'(fetch_valid), 32'd0);

    // Program row 5 and fetch it
    prog(6'd5, 32'hDEADBEEF);
    fetch_check("fetch_row5", 32'h14, 32'hDEADBEEF, 1'b0);
    tick();
    check("pulse_one_cycle", 32'(fetch_valid), 32'd0);
    check("rdata_hold", read_data, 32'hDEADBEEF);

    // Same-cycle write and fetch of row 3 returns old data
    prog(6'd3, 32'hAAAA5555);
    prog_we = 1'b1; prog_addr = 6'd3; prog_data = 32'h12345678;
    fetch_check("rw_same_row", 32'h0C, 32'hAAAA5555, 1'b0);
    prog_we = 1'b0;
    fetch_check("refetch_row3", 32'h0C, 32'h12345678, 1'b0);

    // Back-to-back fetches
    prog(6'd7, 32'h11111111);
    prog(6'd8, 32'h22222222);
    prog(6'd0, 32'h0BADF00D);
    fetch_req = 1'b1;
    address = 32'h1C; tick();
    check("b2b0_valid", 32'(fetch_valid), 32'd1);
    check("b2b0_data", read_data, 32'h11111111);
    address = 32'h20; tick();
    check("b2b1_valid", 32'(fetch_valid), 32'd1);
    check("b2b1_data", read_data, 32'h22222222);
    address = 32'h14; tick();
    check("b2b2_valid", 32'(fetch_valid), 32'd1);
    check("b2b2_data", read_data, 32'hDEADBEEF);
    fetch_req = 1'b0;
    tick();
    check("b2b_end_valid", 32'(fetch_valid), 32'd0);

    // Out-of-range and misaligned addresses
`ifdef IMEM_FAULT_CHECK_EN
    fetch_check("oob_0x114", 32'h114, 32'h00000013, 1'b1);
    fetch_check("mis_0x102", 32'h102, 32'h00000013, 1'b1);
`else
    fetch_check("wrap_0x114", 32'h114, 32'hDEADBEEF, 1'b0);
    fetch_check("wrap_0x102", 32'h102, 32'h0BADF00D, 1'b0);
`endif
    fetch_check("after_fault", 32'h1C, 32'h11111111, 1'b0);

    // Reset with a fetch pending suppresses the result
    reset = 1'b1; fetch_req = 1'b1; address = 32'h14;
    tick();
    reset = 1'b0; fetch_req = 1'b0;
    check("rstfetch_valid", 32'(fetch_valid), 32'd0);
    check("rstfetch_rdata", read_data, 32'h0);
    check("rstfetch_busy", 32'(busy), 32'd1);

    // Partial sweep to row 30, then restart
    for (int i = 0; i < 30; i++) tick();
    check("midsweep_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // Full sweep again; loader and fetch requests are dropped meanwhile
    n = 0;
    while (busy && n < 200) begin
      n++;
      if (n == 50) begin
        prog_we = 1'b1; prog_addr = 6'd10; prog_data = 32'hCAFEBABE;
        fetch_req = 1'b1; address = 32'h28;
      end
      if (n == 53) begin
        prog_we = 1'b0; fetch_req = 1'b0;
      end
      tick();
      if (fetch_valid !== 1'b0) check("clear_no_valid", 32'(fetch_valid), 32'd0);
    end
    prog_we = 1'b0; fetch_req = 1'b0;
    check("restart_cycles", 32'(n), 32'd64);

    fetch_check("dropped_write", 32'h28, 32'h0, 1'b0);
    fetch_check("row5_cleared", 32'h14, 32'h0, 1'b0);
    fetch_check("row0_cleared", 32'h00, 32'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_memory_bank.md
INSTRUCTION_MEMORY_BANK -- requirements
Module: instruction_memory_bank

Interface
REQ-001 The block SHALL provide parameter DEPTH, default 64, number of 32-bit instruction rows (power of two, 16..4096).
REQ-002 The block SHALL provide parameter IDX_W, default $clog2(DEPTH), row-index width.
REQ-003 CLK  input  1  single clock, all logic on rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 FetchReq  input  1  fetch request, sampled each cycle.
REQ-006 Address  input  32  byte address of the instruction to fetch.
REQ-007 ReadData  output  32  fetched instruction word, registered.
REQ-008 FetchValid  output  1  one-cycle pulse qualifying ReadData.
REQ-009 Busy  output  1  high while memory is being cleared; fetch and program inputs are ignored.
REQ-010 ProgWE  input  1  program-port write enable (loader).
REQ-011 ProgAddr  input  IDX_W  program-port row index.
REQ-012 ProgData  input  32  program-port write data.
REQ-013 Fault  output  1  fetch-address fault flag, qualified by FetchValid.

Function
REQ-014 Row index SHALL be Address[IDX_W+1:2] (word addressing from byte address).
REQ-015 States SHALL be CLEAR and IDLE; RESET high forces CLEAR with sweep pointer 0.
REQ-016 In CLEAR, one row per cycle SHALL be written 0x00000000, pointer 0..DEPTH-1; after row DEPTH-1 is written, next state SHALL be IDLE.
REQ-017 Busy SHALL be 1 in CLEAR (including cycles RESET is high) and 0 in IDLE; clear takes exactly DEPTH cycles after RESET falls.
REQ-018 In IDLE, FetchReq=1 at edge N SHALL give ReadData=row contents and FetchValid=1 after edge N (latency 1); FetchValid SHALL be 0 in any cycle not following an accepted request.
REQ-019 Back-to-back FetchReq SHALL give one result per cycle, no bubbles.
REQ-020 ReadData SHALL hold its last value when FetchValid=0.
REQ-021 In IDLE, ProgWE=1 SHALL write ProgData to row ProgAddr at the edge.
REQ-022 Simultaneous fetch and program write to the same row SHALL return the old (pre-write) data; the write SHALL still complete.
REQ-023 FetchReq and ProgWE during CLEAR SHALL be dropped: no write, no FetchValid.
REQ-024 Without fault checking, address bits above IDX_W+1 and bits [1:0] SHALL be ignored (index wraps modulo DEPTH).

Reset
REQ-025 On RESET: ReadData=0x00000000, FetchValid=0, Fault=0, Busy=1, state=CLEAR, pointer=0.
REQ-026 RESET asserted mid-sweep SHALL restart the sweep from row 0; asserted with FetchReq pending SHALL suppress that FetchValid.

Configuration
REQ-027 Macro IMEM_FAULT_CHECK_EN SHALL enable address fault checking.
REQ-028 With IMEM_FAULT_CHECK_EN: fetch with Address[1:0]!=0 or Address>=4*DEPTH SHALL give FetchValid=1, Fault=1, ReadData=0x00000013 (NOP), memory not read.
REQ-029 With IMEM_FAULT_CHECK_EN, Fault SHALL be 0 on every non-faulting fetch and whenever FetchValid=0.
REQ-030 Without IMEM_FAULT_CHECK_EN: Fault SHALL be tied 0, and REQ-024 applies.

Verification
REQ-031 RESET 1 cycle, then count Busy -> Busy high exactly 64 cycles (DEPTH=64), then fetch of 0x00000010 returns 0x00000000.
REQ-032 Program row 5=0xDEADBEEF, then fetch Address 0x14 -> next cycle ReadData=0xDEADBEEF, FetchValid=1 for one cycle.
REQ-033 Same-cycle ProgWE row 3=0x12345678 and fetch 0x0C (old 0xAAAA5555) -> ReadData=0xAAAA5555; refetch -> 0x12345678.
REQ-034 Fetch 0x102 with macro -> Fault=1, ReadData=0x00000013; without macro -> Fault=0, ReadData=row 0.
REQ-035 RESET at sweep row 30, ProgWE during sweep -> sweep restarts at 0, Busy 64 further cycles after RESET falls, written row reads 0.
